// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt sequencer: FSM state encoding,
// vector-width derivation and one-hot decode.
package irq_pkg;

    localparam int MAX_IRQ   = 16;
    localparam int MAX_VEC_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    // Smallest w with 2**w >= n; VEC_W must equal clog2(NUM_IRQ).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_IRQ-1:0] onehot(input logic [MAX_VEC_W-1:0] vec);
        return MAX_IRQ'(1) << vec;
    endfunction

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational winner selection among candidate sources: lowest index in
// fixed mode, or nearest index at/after rr_ptr (wrapping) in round-robin mode.
module irq_prio_sel
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int VEC_W       = 2,
    parameter int ROUND_ROBIN = 0
) (
    input  logic [NUM_IRQ-1:0] cand_i,
    input  logic [VEC_W-1:0]   rr_ptr_i,
    output logic               valid_o,
    output logic [VEC_W-1:0]   sel_o
);

    // Each candidate gets a distance from the search start; the smallest wins.
    always_comb begin
        int best_d;
        int d;
        valid_o = 1'b0;
        sel_o   = '0;
        best_d  = NUM_IRQ;
        d       = 0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ROUND_ROBIN != 0) begin
                d = i - int'(rr_ptr_i);
                if (d < 0) d = d + NUM_IRQ;
            end else begin
                d = i;
            end
            if (cand_i[i] && (d < best_d)) begin
                best_d  = d;
                valid_o = 1'b1;
                sel_o   = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer: captures source rising edges, masks, prioritises and
// runs a non-nested request/ack/eoi handshake with a single CPU line.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int VEC_W       = 2,
    parameter int ROUND_ROBIN = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [VEC_W-1:0]   irq_vector,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] pending
);

    state_e             state_q, state_d;
    logic               int_req_q, int_req_d;
    logic [VEC_W-1:0]   irq_vector_q, irq_vector_d;
    logic [NUM_IRQ-1:0] in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [VEC_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] vec_oh;
    logic               sel_valid;
    logic [VEC_W-1:0]   sel_idx;

    assign irq_rise = irq_in & ~irq_prev_q;
    assign cand     = pending_q & ~mask;
    assign vec_oh   = NUM_IRQ'(onehot(MAX_VEC_W'(irq_vector_q)));

    irq_prio_sel #(
        .NUM_IRQ     (NUM_IRQ),
        .VEC_W       (VEC_W),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_prio_sel (
        .cand_i   (cand),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (sel_valid),
        .sel_o    (sel_idx)
    );

    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        irq_vector_d = irq_vector_q;
        in_service_d = in_service_q;
        pending_d    = pending_q;
        rr_ptr_d     = rr_ptr_q;

        case (state_q)
            IDLE: begin
                if (enable && sel_valid) begin
                    irq_vector_d = sel_idx;
                    int_req_d    = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                // Ack takes precedence over a mask that rises in the same cycle.
                if (int_ack) begin
                    pending_d    = pending_q & ~vec_oh;
                    in_service_d = vec_oh;
                    int_req_d    = 1'b0;
                    state_d      = SERVICE;
                end else if (|(mask & vec_oh)) begin
                    int_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d = '0;
                    rr_ptr_d     = (irq_vector_q == VEC_W'(NUM_IRQ - 1)) ? '0
                                                                         : irq_vector_q + 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                int_req_d = 1'b0;
            end
        endcase

        // A new edge on the source being acked re-arms it.
        pending_d = pending_d | irq_rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            int_req_q    <= 1'b0;
            irq_vector_q <= '0;
            in_service_q <= '0;
            pending_q    <= '0;
            irq_prev_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            irq_vector_q <= irq_vector_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            irq_prev_q   <= irq_in;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign int_req    = int_req_q;
    assign irq_vector = irq_vector_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;

endmodule
